mem_addr_responder: RTL and testbench
=====================================

Name: mem_addr_responder

Overview:
- Memory-side consumer of the shared address bus.
- Samples the bus address when a single read or write request is raised and waits a programmable settle time that models relay settling.
- Then performs the access on an internal byte array and returns a one-cycle acknowledge.
- For reads it drives the data bus through an output-enable until the request is released. It is the responding end of the address-bus sources (M, XY, J, PC, INC).

Parameters:
- ADDR_BUS_WIDTH, 8, address bus width; memory depth is 2**ADDR_BUS_WIDTH.
- DATA_WIDTH, 8, data bus width.
- SETTLE_CYCLES, 3, cycles the address must be held stable before the access; legal range 1..15.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- addr  input  ADDR_BUS_WIDTH  address bus value.
- rd_req  input  1  read request (level).
- wr_req  input  1  write request (level).
- data_in  input  DATA_WIDTH  write data from the data bus.
- data_out  output  DATA_WIDTH  read data.
- data_oe  output  1  high while this block drives data_out onto the data bus.
- ack  output  1  one-cycle pulse when the access completes.
- busy  output  1  high in every state except IDLE.
- abort  output  1  one-cycle pulse when a request is withdrawn before the access.
- err  output  1  one-cycle pulse when rd_req and wr_req are both high in IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset values: state IDLE; data_out=0, data_oe=0, ack=0, busy=0, abort=0, err=0, settle counter 0, latched address 0, latched op 0. Memory contents are not cleared by reset.
- All outputs are registered.
- FSM states: IDLE, SETTLE, ACCESS, HOLD.
- IDLE, exactly one request high at an edge:
  - Latch addr into addr_q and the op (rd or wr); clear the counter; go to SETTLE.
  - busy is high from the next cycle.
- IDLE, both requests high: stay in IDLE; err pulses high for one cycle; nothing is latched. err repeats every cycle both requests stay high.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to ACCESS.
  - If the latched request goes low, or the opposite request goes high: go to IDLE, abort pulses for one cycle, no memory write, no ack.
  - The addr bus is not re-sampled in SETTLE; addr_q is authoritative.
- ACCESS, one cycle:
  - Write: mem[addr_q] <= data_in sampled this cycle.
  - Read: data_out <= mem[addr_q].
  - Next state HOLD.
  - The request is not checked here; the access always completes once ACCESS is entered.
- HOLD:
  - ack is high in the first HOLD cycle only.
  - Read: data_oe is high for the entire HOLD stay and data_out is stable.
  - Write: data_oe stays 0.
  - Stay while the latched request is high. When both requests are low: go to IDLE; data_oe and busy fall at that edge.
  - A new request can be accepted no earlier than the first IDLE cycle; there is no back-to-back accept without a release.
- Latency: with the acceptance edge as edge 0, ack is high in the cycle after edge SETTLE_CYCLES+1. For SETTLE_CYCLES=3, ack is high after edge 4.
- Read-after-write to the same address returns the new data.
- Address wrap: the full address range is valid; there are no out-of-range addresses.
- Reset mid-operation: return to IDLE on that edge with outputs at reset values. A write that has not reached ACCESS is not performed; memory written in earlier completed accesses is retained.
- data_oe is never high outside HOLD.

Test Plan:
- Reset then write 0xA5 to addr 0x3C: wr_req held from edge 0 -> busy high from edge 1, ack high after edge 4 only, data_oe stays 0; drop wr_req -> busy low next edge.
- Read addr 0x3C after the write: rd_req held -> ack after edge 4, data_out=0xA5 with data_oe=1 until rd_req drops, then data_oe=0 on the next edge.
- Abort: wr 0x11 to 0x3C, drop wr_req after edge 2 -> abort pulses once, no ack, busy=0; a later read of 0x3C returns 0xA5.
- Simultaneous requests: rd_req=wr_req=1 in IDLE for 2 cycles -> err high for 2 cycles, busy stays 0; then drop wr_req -> read accepted normally.
- Address changes during SETTLE: start read at 0x3C, bus switches to 0x00 after edge 1 -> data_out=0xA5 (latched address used).
- Reset mid-SETTLE of a write of 0x77 to 0xFF: reset_n low one cycle -> all outputs 0; a later read of 0xFF returns its prior value, not 0x77. Wrap check: write 0x5A at 0xFF and 0x5B at 0x00 -> both read back correctly.

Source files
------------

// File: rtl/mem_addr_responder.sv
// Memory-side responder on the shared address bus: latches the address, waits a
// settle time, performs one read or write on an internal byte array, then acks.
module mem_addr_responder #(
  parameter int unsigned ADDR_BUS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES  = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_BUS_WIDTH-1:0] addr,
  input  logic                      rd_req,
  input  logic                      wr_req,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_oe,
  output logic                      ack,
  output logic                      busy,
  output logic                      abort,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCESS, HOLD} state_t;

  state_t                    state, state_d;
  logic [3:0]                cnt, cnt_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic                      op_wr;
  logic                      accept, withdraw;
  logic [DATA_WIDTH-1:0]     data_out_d;
  logic                      data_oe_d, ack_d, busy_d, abort_d, err_d;

  logic [DATA_WIDTH-1:0]     mem [2**ADDR_BUS_WIDTH];

  assign accept   = (state == IDLE) && (rd_req ^ wr_req);
  // Withdrawal: the latched request dropped, or the opposite one was raised.
  assign withdraw = op_wr ? (!wr_req || rd_req) : (!rd_req || wr_req);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      op_wr    <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      abort    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      data_out <= data_out_d;
      data_oe  <= data_oe_d;
      ack      <= ack_d;
      busy     <= busy_d;
      abort    <= abort_d;
      err      <= err_d;
      if (accept) begin
        addr_q <= addr;
        op_wr  <= wr_req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && state == ACCESS && op_wr) begin
      mem[addr_q] <= data_in;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (withdraw) begin
          state_d = IDLE;
        end else if (cnt == 4'(SETTLE_CYCLES - 1)) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      ACCESS: state_d = HOLD;
      HOLD: begin
        if (!rd_req && !wr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each is computed from the transition being taken.
  always_comb begin
    ack_d      = (state == ACCESS);
    abort_d    = (state == SETTLE) && withdraw;
    err_d      = (state == IDLE) && rd_req && wr_req;
    busy_d     = (state_d != IDLE);
    data_oe_d  = (state_d == HOLD) && !op_wr;
    data_out_d = data_out;
    if (state == ACCESS && !op_wr) begin
      data_out_d = mem[addr_q];
    end
  end

endmodule

// File: tb/tb_mem_addr_responder.sv
// Randomized and directed checks of mem_addr_responder against a cycle-timeline
// reference model holding the expected memory contents.
module tb_mem_addr_responder;

  localparam int S = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] addr;
  logic       rd_req, wr_req;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe, ack, busy, abort, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mref [256];
  bit         mval [256];

  mem_addr_responder #(
    .ADDR_BUS_WIDTH(8),
    .DATA_WIDTH(8),
    .SETTLE_CYCLES(S)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .addr(addr),
    .rd_req(rd_req),
    .wr_req(wr_req),
    .data_in(data_in),
    .data_out(data_out),
    .data_oe(data_oe),
    .ack(ack),
    .busy(busy),
    .abort(abort),
    .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drop_at >= 0: requests released after edge drop_at (must be < S), so the
  // access is aborted. hold: extra HOLD cycles before the request is released.
  task automatic run_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int drop_at, input int hold, input bit scramble);
    bit         known;
    logic [7:0] exp_d;
    known  = mval[a];
    exp_d  = mref[a];
    addr    = a;
    data_in = d;
    wr_req  = wr;
    rd_req  = !wr;
    tick();
    check_eq("err_on_accept", err, 0);
    check_eq("oe_on_accept", data_oe, 0);
    for (int k = 1; k <= S + 1; k++) begin
      if (k == 2 && scramble) addr = 8'($urandom);
      if (drop_at == k - 1) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      tick();
      if (drop_at == k - 1) begin
        check_eq("abort_pulse", abort, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ack", ack, 0);
        check_eq("abort_oe", data_oe, 0);
        tick();
        check_eq("abort_once", abort, 0);
        check_eq("abort_no_late_ack", ack, 0);
        return;
      end
      if (k <= S) begin
        check_eq("settle_busy", busy, 1);
        check_eq("settle_ack", ack, 0);
        check_eq("settle_oe", data_oe, 0);
        check_eq("settle_abort", abort, 0);
      end
    end
    check_eq("ack_latency", ack, 1);
    check_eq("hold_busy", busy, 1);
    check_eq("hold_oe", data_oe, !wr);
    if (!wr && known) check_eq("read_data", data_out, exp_d);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("ack_single", ack, 0);
      check_eq("hold_busy_stay", busy, 1);
      check_eq("hold_oe_stay", data_oe, !wr);
      if (!wr && known) check_eq("read_data_stable", data_out, exp_d);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    check_eq("release_busy", busy, 0);
    check_eq("release_oe", data_oe, 0);
    check_eq("release_ack", ack, 0);
    if (wr) begin
      mref[a] = d;
      mval[a] = 1'b1;
    end
  endtask

  initial begin
    foreach (mval[i]) mval[i] = 1'b0;
    reset_n = 1'b0;
    addr    = '0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    data_in = '0;
    tick();
    tick();
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_oe", data_oe, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_abort", abort, 0);
    check_eq("rst_err", err, 0);
    reset_n = 1'b1;
    tick();

    run_op(1'b1, 8'h3C, 8'hA5, -1, 2, 1'b0);
    run_op(1'b0, 8'h3C, 8'h00, -1, 3, 1'b0);
    check_eq("directed_read_a5", mref[8'h3C] == 8'hA5, 1);
    run_op(1'b1, 8'h3C, 8'h11, 2, 0, 1'b0);
    run_op(1'b0, 8'h3C, 8'h00, -1, 1, 1'b0);

    addr   = 8'h3C;
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    check_eq("err_cycle1", err, 1);
    check_eq("err_busy1", busy, 0);
    tick();
    check_eq("err_cycle2", err, 1);
    check_eq("err_busy2", busy, 0);
    run_op(1'b0, 8'h3C, 8'h00, -1, 0, 1'b0);
    run_op(1'b0, 8'h3C, 8'h00, -1, 1, 1'b1);

    run_op(1'b1, 8'hFF, 8'h5A, -1, 0, 1'b0);
    addr    = 8'hFF;
    data_in = 8'h77;
    wr_req  = 1'b1;
    tick();
    tick();
    check_eq("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_ack", ack, 0);
    check_eq("rst_mid_oe", data_oe, 0);
    check_eq("rst_mid_dout", data_out, 0);
    check_eq("rst_mid_abort", abort, 0);
    check_eq("rst_mid_err", err, 0);
    reset_n = 1'b1;
    wr_req  = 1'b0;
    tick();
    check_eq("rst_mid_idle", busy, 0);
    run_op(1'b0, 8'hFF, 8'h00, -1, 0, 1'b0);
    run_op(1'b1, 8'h00, 8'h5B, -1, 0, 1'b0);
    run_op(1'b0, 8'hFF, 8'h00, -1, 0, 1'b0);
    run_op(1'b0, 8'h00, 8'h00, -1, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      bit         wr;
      logic [7:0] a;
      int         drop;
      wr   = ($urandom_range(0, 1) == 1);
      a    = 8'($urandom_range(0, 7) * 37);
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, S - 1)) : -1;
      run_op(wr, a, 8'($urandom), drop, int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
